ped_signal_unit: RTL and testbench
==================================

# ped_signal_unit

Pedestrian-side endpoint of the T-intersection controller's crossing protocol. It synchronises and debounces the raw push-button and holds a request line for `traffic_controller` until that request is served. It observes the controller's `mode` bus and drives the pedestrian WALK / DON'T-WALK heads, including a flashing clearance interval with a countdown. It sits between the kerbside button/lamp hardware and the controller's `I` input.

## Interface
- `DEBOUNCE_CYC`, default 2: consecutive synchronised-high cycles required to accept a press.
- `WALK_CYC`, default 20: steady WALK duration, in cycles.
- `CLEAR_CYC`, default 10: flashing DON'T-WALK clearance duration, in cycles. `WALK_CYC + CLEAR_CYC` equals the controller's mode-0 length of 30 cycles.
- `CNT_W`, default 5: counter and countdown width. Must satisfy 2^CNT_W > max(`WALK_CYC`, `CLEAR_CYC`, `DEBOUNCE_CYC`).

- `clk` in 1: system clock (1 Hz in the intersection build).
- `rst_n` in 1: asynchronous, active-low reset.
- `btn` in 1: raw, asynchronous pedestrian push-button.
- `mode` in 2: controller mode; 0 = pedestrian phase, 1–3 = vehicle phases.
- `ped_req` out 1: request to the controller (connects to its `I`).
- `wait_lamp` out 1: "request registered" indicator; equal to `ped_req`.
- `walk` out 1: WALK head.
- `dont_walk` out 1: DON'T-WALK head; steady or flashing.
- `countdown` out CNT_W: remaining clearance cycles.

## Operation
- **Button path.** `btn` passes through a 2-FF synchroniser, then a debounce counter.
  - The counter increments while the synchronised level is 1 and clears on 0.
  - A single-cycle `press` fires when the counter reaches `DEBOUNCE_CYC`. At most one press per hold.
- **Request latch (`ped_req`).**
  - Set by `press` in states DONT_WALK or CLEAR.
  - A press in WALK is ignored.
  - Cleared on the cycle `mode` transitions from non-zero to 0 (`mode_q != 0 && mode == 0`). This is the service acknowledge.
  - If a press and a clear occur in the same cycle, the clear wins.
- **Phase FSM.** States are DONT_WALK, WALK and CLEAR; a phase counter runs alongside.
  - DONT_WALK → WALK: on the mode-0 entry edge. The counter loads `WALK_CYC-1`.
  - WALK → CLEAR: when the counter reaches 0. The counter loads `CLEAR_CYC-1`.
  - CLEAR → DONT_WALK: when the counter reaches 0.
  - From WALK or CLEAR, if `mode != 0` the FSM goes to DONT_WALK immediately. This is an early abort.
  - Mode-0 entry while already in WALK or CLEAR does not restart the FSM.
- **Lamp outputs by state.**
  - DONT_WALK: `walk`=0, `dont_walk`=1.
  - WALK: `walk`=1, `dont_walk`=0.
  - CLEAR: `walk`=0, and `dont_walk` toggles every cycle, starting at 1 on CLEAR entry.
- **Fail-safe.** `walk` and `dont_walk` are never both 1 in the same cycle.
- **Countdown.** During CLEAR, `countdown` = phase counter + 1, giving `CLEAR_CYC` down to 1. It is 0 in all other states.

## Timing
- **Reset values:**
  - FSM in DONT_WALK.
  - `ped_req`=0, `wait_lamp`=0, `walk`=0, `dont_walk`=1, `countdown`=0.
  - Synchroniser, debounce counter and `mode_q` cleared.
  - All outputs are registered.
- **Button-to-request latency:** `btn` rising to `ped_req` rising takes 2 + `DEBOUNCE_CYC` + 1 edges (5 cycles at the default).
- **Mode-to-lamp latency:** `walk` rises 1 cycle after `mode` becomes 0, and `ped_req` falls on that same edge.
- **Phase lengths:** WALK lasts exactly `WALK_CYC` cycles and CLEAR lasts exactly `CLEAR_CYC` cycles.
- **Reset mid-phase:** asserting `rst_n` low forces DON'T-WALK asynchronously. Any pending request is lost.

## Configuration
- `PED_COUNTDOWN_EN` defined: `countdown` is driven as described above.
- Not defined: `countdown` is tied to 0 and the countdown decode logic is omitted. The phase counter remains, because it is needed for CLEAR timing.

## Structure
- Package `ped_pkg` contains:
  - the `ped_state_t` enum (DONT_WALK, WALK, CLEAR);
  - the `MODE_PED` = 2'd0 constant;
  - default timing constants.
- Sub-module `ped_debounce` contains the synchroniser plus debounce counter and produces `press`.

## Test plan
- Reset, then idle with `mode` cycling 1→2→3 → `dont_walk`=1, `walk`=0 and `ped_req`=0 throughout.
- `btn`=1 for 4 cycles at t=0 → `ped_req`=1 at cycle 5. Hold `btn` 40 cycles → only one press and no re-trigger.
- With `ped_req`=1, drive `mode`=0 for 30 cycles →
  - `ped_req` falls on the entry edge;
  - `walk`=1 for 20 cycles;
  - 10 CLEAR cycles with `dont_walk` toggling and `countdown` running 10→1;
  - then DONT_WALK.
- Press during WALK → `ped_req` stays 0. Press during CLEAR → `ped_req`=1 and is held past mode 0.
- `mode`→1 on WALK cycle 8 → next cycle `walk`=0, `dont_walk`=1, `countdown`=0.
- `rst_n` low mid-CLEAR → immediate reset values. With `PED_COUNTDOWN_EN` undefined, `countdown` stays 0 at all times.

Source files
------------

// File: rtl/ped_pkg.sv
// Shared types and default timing for the pedestrian signal unit.
// Holds the phase state enum, the pedestrian mode code and defaults.
package ped_pkg;

  typedef enum logic [1:0] {
    DONT_WALK = 2'd0,
    WALK      = 2'd1,
    CLEAR     = 2'd2
  } ped_state_t;

  localparam logic [1:0] MODE_PED = 2'd0;

  localparam int DEF_DEBOUNCE_CYC = 2;
  localparam int DEF_WALK_CYC     = 20;
  localparam int DEF_CLEAR_CYC    = 10;
  localparam int DEF_CNT_W        = 5;

endpackage

// File: rtl/ped_signal_unit_debounce.sv
// Button front end: 2-FF synchroniser plus a saturating debounce counter.
// Ports: clk, rst_n, btn (raw async) in; press (one-cycle pulse) out.
module ped_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] DEB    = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] DEB_M1 = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Counter parks at DEB while held, so the
  // DEB-1 -> DEB step happens once per hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (!sync2) begin
        cnt <= '0;
      end else if (cnt != DEB) begin
        cnt <= cnt + CNT_W'(1);
      end
      press <= sync2 && (cnt == DEB_M1);
    end
  end

endmodule

// File: rtl/ped_signal_unit.sv
// Pedestrian endpoint: latches button requests, drives WALK/DON'T-WALK.
// Ports: clk, rst_n, btn, mode in; ped_req, wait_lamp, walk,
// dont_walk, countdown out. Macro PED_COUNTDOWN_EN enables countdown.
module ped_signal_unit
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int WALK_CYC     = DEF_WALK_CYC,
  parameter int CLEAR_CYC    = DEF_CLEAR_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn,
  input  logic [1:0]       mode,
  output logic             ped_req,
  output logic             wait_lamp,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown
);

  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYC - 1);

  logic             press;
  logic [1:0]       mode_q;
  logic             mode_ped;
  logic             entry;
  ped_state_t       state_q;
  ped_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             walk_d;
  logic             dont_walk_d;

  ped_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNT_W        (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .press (press)
  );

  assign mode_ped  = (mode == MODE_PED);
  // Service acknowledge: controller just entered the pedestrian phase.
  assign entry     = (mode_q != MODE_PED) && mode_ped;
  assign wait_lamp = ped_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DONT_WALK: begin
        if (entry) begin
          state_d = WALK;
          cnt_d   = WALK_LD;
        end
      end
      WALK: begin
        if (!mode_ped) begin
          state_d = DONT_WALK;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = CLEAR;
          cnt_d   = CLEAR_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CLEAR: begin
        if (!mode_ped || cnt_q == '0) begin
          state_d = DONT_WALK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = DONT_WALK;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamps are decoded from the next state so they
  // register alongside it; walk and dont_walk are
  // mutually exclusive by construction.
  always_comb begin
    walk_d      = 1'b0;
    dont_walk_d = 1'b1;
    unique case (state_d)
      WALK: begin
        walk_d      = 1'b1;
        dont_walk_d = 1'b0;
      end
      CLEAR: begin
        dont_walk_d = (state_q == CLEAR) ? ~dont_walk : 1'b1;
      end
      default: begin
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_PED;
      ped_req   <= 1'b0;
      state_q   <= DONT_WALK;
      cnt_q     <= '0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
    end else begin
      mode_q    <= mode;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      walk      <= walk_d;
      dont_walk <= dont_walk_d;
      // Acknowledge beats a coincident press.
      if (entry) begin
        ped_req <= 1'b0;
      end else if (press && state_q != WALK) begin
        ped_req <= 1'b1;
      end
    end
  end

`ifdef PED_COUNTDOWN_EN
  logic [CNT_W-1:0] countdown_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countdown_q <= '0;
    end else if (state_d == CLEAR) begin
      countdown_q <= cnt_d + CNT_W'(1);
    end else begin
      countdown_q <= '0;
    end
  end

  assign countdown = countdown_q;
`else
  assign countdown = '0;
`endif

endmodule

// File: tb/tb_ped_signal_unit.sv
// Scoreboard bench for ped_signal_unit against a timeline model.
// Driver pushes expected outputs; a monitor pops and compares.
module tb_ped_signal_unit;

  localparam int DEB   = 2;
  localparam int WC    = 20;
  localparam int CC    = 10;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             btn = 1'b0;
  logic [1:0]       mode = 2'd1;
  logic             ped_req;
  logic             wait_lamp;
  logic             walk;
  logic             dont_walk;
  logic [CNT_W-1:0] countdown;

  ped_signal_unit #(
    .DEBOUNCE_CYC (DEB),
    .WALK_CYC     (WC),
    .CLEAR_CYC    (CC),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .mode      (mode),
    .ped_req   (ped_req),
    .wait_lamp (wait_lamp),
    .walk      (walk),
    .dont_walk (dont_walk),
    .countdown (countdown)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             pr;
    logic             w;
    logic             dw;
    logic [CNT_W-1:0] cd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: edge index, run lengths of
  // sampled button highs, phase start edge.
  int         edge_n;
  int         runs[4];
  logic [1:0] pm;
  bit         m_req;
  bit         m_active;
  int         m_start;
  bit         prev_walk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) runs[i] = 0;
    pm        = 2'd0;
    m_req     = 1'b0;
    m_active  = 1'b0;
    m_start   = 0;
    prev_walk = 1'b0;
  endfunction

  function automatic void model_step(input logic b, input logic [1:0] m);
    bit   press;
    bit   entry;
    int   t;
    exp_t e;
    edge_n++;
    for (int i = 3; i > 0; i--) runs[i] = runs[i-1];
    runs[0] = b ? runs[1] + 1 : 0;
    // A hold is accepted once: sync delay 2, debounce DEB,
    // register 1 -> run of DEB highs seen three edges ago.
    press = (runs[3] == DEB);
    entry = (m == 2'd0) && (pm != 2'd0);
    if (entry) m_req = 1'b0;
    else if (press && !prev_walk) m_req = 1'b1;
    if (m_active && m != 2'd0) begin
      m_active = 1'b0;
    end else if (!m_active && entry) begin
      m_active = 1'b1;
      m_start  = edge_n;
    end
    t = edge_n - m_start;
    if (m_active && t >= WC + CC) m_active = 1'b0;
    e.pr = m_req;
    e.w  = m_active && (t < WC);
    e.dw = 1'b1;
    e.cd = '0;
    if (m_active && t < WC) e.dw = 1'b0;
    if (m_active && t >= WC) begin
      e.dw = ((t - WC) % 2) == 0;
`ifdef PED_COUNTDOWN_EN
      e.cd = CNT_W'(WC + CC - t);
`endif
    end
    prev_walk = e.w;
    pm = m;
    q.push_back(e);
  endfunction

  task automatic step(input logic b, input logic [1:0] m);
    @(negedge clk);
    btn  = b;
    mode = m;
    @(posedge clk);
    model_step(b, m);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ped_req"}, int'(ped_req), 0);
    chk({tag, "_wait_lamp"}, int'(wait_lamp), 0);
    chk({tag, "_walk"}, int'(walk), 0);
    chk({tag, "_dont_walk"}, int'(dont_walk), 1);
    chk({tag, "_countdown"}, int'(countdown), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_checks(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compares DUT against whatever the driver queued.
  always begin
    @(posedge clk);
    #1;
    if (rst_n && q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("ped_req", int'(ped_req), int'(e.pr));
      chk("wait_lamp", int'(wait_lamp), int'(e.pr));
      chk("walk", int'(walk), int'(e.w));
      chk("dont_walk", int'(dont_walk), int'(e.dw));
      chk("countdown", int'(countdown), int'(e.cd));
      chk("failsafe", int'(walk & dont_walk), 0);
    end
  end

  initial begin
    logic       b;
    logic [1:0] m;
    edge_n = 0;
    model_reset();
    #12;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) step(1'b0, 2'(1 + i % 3));

    for (int i = 0; i < 44; i++) step(1'b1, 2'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd3);

    for (int i = 0; i < 30; i++)
      step((i >= 3 && i < 7) || (i >= 22 && i < 26), 2'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 2'd1);

    for (int i = 0; i < 8; i++) step(1'b0, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 2'd1);

    for (int i = 0; i < 25; i++) step(1'b0, 2'd0);
    do_reset("mid_clear");

    b = 1'b0;
    for (int s = 0; s < 90; s++) begin
      int len;
      len = $urandom_range(2, 14);
      m = 2'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) b = ~b;
        if ($urandom_range(0, 5) == 0) m = 2'($urandom_range(1, 3));
        step(b, m);
      end
      len = $urandom_range(3, 36);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 9) == 0) b = ~b;
        step(b, 2'd0);
      end
    end

    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
